// File: rtl/fifo_test_pkg.sv
// Shared types and pattern generator for the FIFO loopback self-test.
// Pattern words are computed at a fixed wide width and narrowed by the caller.
package fifo_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        REPORT
    } state_t;

    localparam int MODE_INC = 0;
    localparam int MODE_ALT = 1;
    localparam int PAT_W    = 64;

    // Word idx of the test pattern; callers truncate to their data width,
    // which also gives the modulo-2^DATA_W wrap of the incrementing mode.
    function automatic logic [PAT_W-1:0] pattern_word(
        input logic [PAT_W-1:0] seed,
        input int               mode,
        input int unsigned      idx
    );
        if (mode == MODE_ALT) begin
            return idx[0] ? ~seed : seed;
        end
        return seed + PAT_W'(idx);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and count-derived full/empty flags.
// Writes when full and reads when empty are dropped without side effects.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_q;
    logic              w_do_wr;
    logic              w_do_rd;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_wr   = i_wr_en && !o_full;
    assign w_do_rd   = i_rd_en && !o_empty;
    assign o_rd_data = r_q;

    // NOTE: storage is deliberately left out of reset; pointers and count
    // define what is valid, so clearing the array would only cost logic.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_q      <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_q      <= r_mem[r_rd_ptr];
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_loopback_tester.sv
// FIFO self-test: writes a BURST-word pattern, reads it back, counts mismatches
// and reports the verdict on status outputs and active-low RGB LEDs.
module fifo_loopback_tester
    import fifo_test_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter int               DEPTH  = 16,
    parameter int               BURST  = 3,
    parameter logic [PAT_W-1:0] SEED   = 8'h65,
    parameter int               MODE   = MODE_INC
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic                       START,
    input  logic                       INJECT,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       PASS,
    output logic [$clog2(BURST+1)-1:0] ERR_COUNT,
    output logic [$clog2(BURST+1)-1:0] FIRST_ERR_IDX,
    output logic                       FIFO_FULL,
    output logic                       FIFO_EMPTY,
    output logic                       LED_R,
    output logic                       LED_G,
    output logic                       LED_B
);

    localparam int            CW         = $clog2(BURST + 1);
    localparam logic [CW-1:0] LAST_IDX   = CW'(BURST - 1);
    localparam logic [CW-1:0] BURST_CNT  = CW'(BURST);

    if (BURST < 1 || BURST > DEPTH) begin : g_bad_burst
        $error("fifo_loopback_tester: BURST must be in 1..DEPTH");
    end
    if (DATA_W < 2 || DATA_W > PAT_W) begin : g_bad_width
        $error("fifo_loopback_tester: DATA_W out of range");
    end
    if (MODE != MODE_INC && MODE != MODE_ALT) begin : g_bad_mode
        $error("fifo_loopback_tester: unknown MODE");
    end

    state_t            r_state;
    state_t            w_next_state;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_busy;
    logic [CW-1:0]     r_wr_idx;
    logic [CW-1:0]     r_rd_cnt;
    logic [CW-1:0]     r_cmp_idx;
    logic [CW-1:0]     r_err_count;
    logic [CW-1:0]     r_first_err_idx;
    logic              r_rd_vld;
    logic              r_done;
    logic              r_pass;
    logic [DATA_W-1:0] w_wr_pat;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_exp_data;
    logic [DATA_W-1:0] w_fifo_q;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    assign w_wr_pat   = DATA_W'(pattern_word(SEED, MODE, 32'(r_wr_idx)));
    assign w_wr_data  = w_wr_pat ^ DATA_W'(INJECT && (r_wr_idx == CW'(1)));
    assign w_exp_data = DATA_W'(pattern_word(SEED, MODE, 32'(r_cmp_idx)));

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk     (CLOCK),
        .i_rst     (RESET),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_fifo_q),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_rd_en      = 1'b0;
        w_busy       = 1'b0;
        unique case (r_state)
            IDLE, REPORT: begin
                if (START) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                w_busy  = 1'b1;
                w_wr_en = 1'b1;
                if (r_wr_idx == LAST_IDX) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                w_busy  = 1'b1;
                w_rd_en = (r_rd_cnt != BURST_CNT);
                if (r_rd_vld && r_cmp_idx == LAST_IDX) begin
                    w_next_state = REPORT;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // r_rd_vld marks the cycle in which registered FIFO data belongs to a read.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_wr_idx        <= '0;
            r_rd_cnt        <= '0;
            r_cmp_idx       <= '0;
            r_rd_vld        <= 1'b0;
            r_err_count     <= '0;
            r_first_err_idx <= BURST_CNT;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_en;
            unique case (r_state)
                IDLE, REPORT: begin
                    if (START) begin
                        r_wr_idx        <= '0;
                        r_err_count     <= '0;
                        r_first_err_idx <= BURST_CNT;
                        r_done          <= 1'b0;
                        r_pass          <= 1'b0;
                    end else if (r_state == REPORT) begin
                        r_done <= 1'b1;
                        r_pass <= (r_err_count == '0);
                    end
                end
                FILL: begin
                    r_wr_idx  <= r_wr_idx + CW'(1);
                    r_rd_cnt  <= '0;
                    r_cmp_idx <= '0;
                end
                DRAIN: begin
                    if (w_rd_en) begin
                        r_rd_cnt <= r_rd_cnt + CW'(1);
                    end
                    if (r_rd_vld) begin
                        r_cmp_idx <= r_cmp_idx + CW'(1);
                        if (w_fifo_q != w_exp_data) begin
                            r_err_count <= r_err_count + CW'(1);
                            if (r_err_count == '0) begin
                                r_first_err_idx <= r_cmp_idx;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY          = w_busy;
    assign DONE          = r_done;
    assign PASS          = r_pass;
    assign ERR_COUNT     = r_err_count;
    assign FIRST_ERR_IDX = r_first_err_idx;
    assign FIFO_FULL     = w_fifo_full;
    assign FIFO_EMPTY    = w_fifo_empty;
    assign LED_B         = ~w_busy;
    assign LED_G         = ~(r_done & r_pass);
    assign LED_R         = ~(r_done & ~r_pass);

endmodule

// File: tb/tb_fifo_loopback_tester.sv
// Self-checking bench: table-driven runs, reset and restart corners, random runs
// against a pattern model, plus full-depth and alternating-pattern instances.
module tb_fifo_loopback_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance: DATA_W=8, DEPTH=16, BURST=3, SEED=65, MODE=0
    logic       d_rst, d_start, d_inject;
    logic       d_busy, d_done, d_pass, d_full, d_empty, d_led_r, d_led_g, d_led_b;
    logic [1:0] d_err, d_first;
    logic [7:0] d_q;

    fifo_loopback_tester u_dut (
        .CLOCK (clk), .RESET (d_rst), .START (d_start), .INJECT (d_inject),
        .BUSY (d_busy), .DONE (d_done), .PASS (d_pass), .ERR_COUNT (d_err),
        .FIRST_ERR_IDX (d_first), .FIFO_FULL (d_full), .FIFO_EMPTY (d_empty),
        .LED_R (d_led_r), .LED_G (d_led_g), .LED_B (d_led_b)
    );
    assign d_q = u_dut.w_fifo_q;

    // Full-depth instance: BURST=DEPTH=16
    logic       b_rst, b_start, b_inject;
    logic       b_busy, b_done, b_pass, b_full, b_empty, b_led_r, b_led_g, b_led_b;
    logic [4:0] b_err, b_first;

    fifo_loopback_tester #(.DATA_W(8), .DEPTH(16), .BURST(16)) u_big (
        .CLOCK (clk), .RESET (b_rst), .START (b_start), .INJECT (b_inject),
        .BUSY (b_busy), .DONE (b_done), .PASS (b_pass), .ERR_COUNT (b_err),
        .FIRST_ERR_IDX (b_first), .FIFO_FULL (b_full), .FIFO_EMPTY (b_empty),
        .LED_R (b_led_r), .LED_G (b_led_g), .LED_B (b_led_b)
    );

    // Alternating-pattern instance: MODE=1, BURST=4
    logic       a_rst, a_start, a_inject;
    logic       a_busy, a_done, a_pass, a_full, a_empty, a_led_r, a_led_g, a_led_b;
    logic [2:0] a_err, a_first;
    logic [7:0] a_q;

    fifo_loopback_tester #(.DATA_W(8), .DEPTH(16), .BURST(4), .SEED(8'h65), .MODE(1)) u_alt (
        .CLOCK (clk), .RESET (a_rst), .START (a_start), .INJECT (a_inject),
        .BUSY (a_busy), .DONE (a_done), .PASS (a_pass), .ERR_COUNT (a_err),
        .FIRST_ERR_IDX (a_first), .FIFO_FULL (a_full), .FIFO_EMPTY (a_empty),
        .LED_R (a_led_r), .LED_G (a_led_g), .LED_B (a_led_b)
    );
    assign a_q = u_alt.w_fifo_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string            tag;
        int               inj_mode;   // 0 low, 1 high through FILL
        int               start_at;   // edge of a spurious START, 0 = none
        bit               exp_pass;
        int               exp_err;
        int               exp_first;
        logic [2:0][7:0]  exp_q;
    } vec_t;

    int              run_lat;
    logic [2:0][7:0] run_q;
    bit              run_hit;
    bit              run_busy_ok;
    bit              run_clr_ok;

    // One run on the default instance; edge 0 samples START.
    task automatic run_default(input int inj_mode, input int start_at);
        d_start  = 1'b1;
        d_inject = (inj_mode == 1);
        step();
        d_start     = 1'b0;
        run_clr_ok  = (d_done === 1'b0) && (d_busy === 1'b1);
        run_busy_ok = 1'b1;
        run_lat     = -1;
        run_hit     = 1'b0;
        run_q       = '0;
        for (int k = 1; k <= 40 && run_lat < 0; k++) begin
            d_start  = (k == start_at);
            d_inject = (inj_mode == 2) ? 1'($urandom_range(0, 1)) : (inj_mode == 1);
            if (k == 2) run_hit = d_inject;
            step();
            if (k >= 4 && k <= 6) run_q[k-4] = d_q;
            if (d_busy !== (k <= 6)) run_busy_ok = 1'b0;
            if (d_done === 1'b1) run_lat = k;
        end
        d_start  = 1'b0;
        d_inject = 1'b0;
    endtask

    task automatic check_run(input string tag, input bit exp_pass, input int exp_err,
                             input int exp_first, input logic [2:0][7:0] exp_q);
        check({tag, " done_edge"}, run_lat, 8);
        check({tag, " busy_window"}, run_busy_ok, 1);
        check({tag, " start_clears"}, run_clr_ok, 1);
        check({tag, " pass"}, d_pass, exp_pass);
        check({tag, " err_count"}, d_err, exp_err);
        check({tag, " first_err"}, d_first, exp_first);
        check({tag, " read_words"}, run_q, exp_q);
        check({tag, " leds"}, {d_led_r, d_led_g, d_led_b}, {exp_pass, ~exp_pass, 1'b1});
    endtask

    // Reference: words stored are the seed-incrementing pattern, with bit 0 of
    // word 1 flipped when INJECT was high while that word was written.
    task automatic model_run(input bit hit, output bit pass, output int err,
                             output int first, output logic [2:0][7:0] q);
        logic [7:0] want, got;
        err   = 0;
        first = 3;
        for (int i = 0; i < 3; i++) begin
            want = 8'h65 + 8'(i);
            got  = want;
            if (i == 1 && hit) got = got ^ 8'h01;
            q[i] = got;
            if (got != want) begin
                if (err == 0) first = i;
                err++;
            end
        end
        pass = (err == 0);
    endtask

    vec_t vecs[4];

    initial begin
        bit              m_pass;
        int              m_err, m_first, gap;
        logic [2:0][7:0] m_q;
        bit              gap_ok;
        int              full_e, empty_e, done_e;
        bit              nonempty;
        logic [3:0][7:0] alt_q;

        vecs[0] = '{tag: "nominal",    inj_mode: 0, start_at: 0, exp_pass: 1, exp_err: 0, exp_first: 3, exp_q: {8'h67, 8'h66, 8'h65}};
        vecs[1] = '{tag: "inject",     inj_mode: 1, start_at: 0, exp_pass: 0, exp_err: 1, exp_first: 1, exp_q: {8'h67, 8'h67, 8'h65}};
        vecs[2] = '{tag: "start_busy", inj_mode: 0, start_at: 3, exp_pass: 1, exp_err: 0, exp_first: 3, exp_q: {8'h67, 8'h66, 8'h65}};
        vecs[3] = '{tag: "restart",    inj_mode: 0, start_at: 0, exp_pass: 1, exp_err: 0, exp_first: 3, exp_q: {8'h67, 8'h66, 8'h65}};

        {d_rst, b_rst, a_rst}          = 3'b111;
        {d_start, b_start, a_start}    = 3'b000;
        {d_inject, b_inject, a_inject} = 3'b000;
        step();
        step();
        {d_rst, b_rst, a_rst} = 3'b000;

        check("rst busy", d_busy, 0);
        check("rst done", d_done, 0);
        check("rst pass", d_pass, 0);
        check("rst err_count", d_err, 0);
        check("rst first_err", d_first, 3);
        check("rst fifo_flags", {d_full, d_empty}, 2'b01);
        check("rst leds", {d_led_r, d_led_g, d_led_b}, 3'b111);
        check("rst big first_err", b_first, 16);

        foreach (vecs[i]) begin
            run_default(vecs[i].inj_mode, vecs[i].start_at);
            check_run(vecs[i].tag, vecs[i].exp_pass, vecs[i].exp_err, vecs[i].exp_first, vecs[i].exp_q);
        end

        // Reset on the first DRAIN edge (edge 4) abandons the run entirely.
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        step(); step(); step();
        d_rst = 1'b1;
        step();
        d_rst = 1'b0;
        check("mid_rst busy", d_busy, 0);
        check("mid_rst done", d_done, 0);
        check("mid_rst fifo_flags", {d_full, d_empty}, 2'b01);
        check("mid_rst leds", {d_led_r, d_led_g, d_led_b}, 3'b111);
        run_default(0, 0);
        check_run("after_rst", 1'b1, 0, 3, {8'h67, 8'h66, 8'h65});

        // Random runs: random INJECT every cycle, random ignored STARTs, random REPORT dwell.
        for (int r = 0; r < 20; r++) begin
            gap    = $urandom_range(0, 3);
            gap_ok = 1'b1;
            for (int g = 0; g < gap; g++) begin
                d_inject = 1'($urandom_range(0, 1));
                step();
                if (d_done !== 1'b1) gap_ok = 1'b0;
            end
            check($sformatf("rnd%0d report_hold", r), gap_ok, 1);
            run_default(2, int'($urandom_range(0, 7)));
            model_run(run_hit, m_pass, m_err, m_first, m_q);
            check_run($sformatf("rnd%0d", r), m_pass, m_err, m_first, m_q);
        end

        // Full-depth run: the FIFO fills completely and the pointers wrap.
        b_start = 1'b1;
        step();
        b_start  = 1'b0;
        full_e   = -1;
        empty_e  = -1;
        done_e   = -1;
        nonempty = 1'b0;
        for (int k = 1; k <= 80 && done_e < 0; k++) begin
            step();
            if (full_e < 0 && b_full === 1'b1) full_e = k;
            if (b_empty === 1'b0) nonempty = 1'b1;
            if (nonempty && empty_e < 0 && b_empty === 1'b1) empty_e = k;
            if (b_done === 1'b1) done_e = k;
        end
        check("big full_edge", full_e, 16);
        check("big empty_edge", empty_e, 32);
        check("big done_edge", done_e, 34);
        check("big pass", b_pass, 1);
        check("big err_count", b_err, 0);
        check("big first_err", b_first, 16);

        // Alternating pattern: reads on edges 5..8.
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        done_e  = -1;
        alt_q   = '0;
        for (int k = 1; k <= 40 && done_e < 0; k++) begin
            step();
            if (k >= 5 && k <= 8) alt_q[k-5] = a_q;
            if (a_done === 1'b1) done_e = k;
        end
        check("alt read_words", alt_q, {8'h9A, 8'h65, 8'h9A, 8'h65});
        check("alt done_edge", done_e, 10);
        check("alt pass", a_pass, 1);
        check("alt err_count", a_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_loopback_tester.md
Name: fifo_loopback_tester

Overview:
Parametrised FIFO self-test block. On each START it writes a BURST-word pattern into an internal synchronous FIFO, reads every word back, compares each against the expected pattern, and reports pass/fail on status outputs and active-low RGB LEDs. It generalises the board-level three-byte FIFO smoke test in four ways: configurable width, depth, burst length and pattern mode, plus error counting, error injection and restartable runs. It sits directly under the board top and drives the LED pins.

Parameters:
DATA_W, 8, FIFO word width in bits (≥ 2).
DEPTH, 16, FIFO depth in words; power of two, ≥ 2.
BURST, 3, words per test run; 1 ≤ BURST ≤ DEPTH. Elaboration error otherwise.
SEED, 8'h65, first pattern word; zero-extended or truncated to DATA_W.
MODE, 0, pattern select:
- 0 = incrementing: word i = SEED + i, modulo 2^DATA_W.
- 1 = alternating: word i = SEED for even i, ~SEED for odd i.

Ports:
CLOCK  in  1  single system clock; all logic on posedge.
RESET  in  1  synchronous, active-high reset.
START  in  1  begin a run; sampled only in IDLE or REPORT.
INJECT  in  1  while high during FILL, word index 1 is written with bit 0 inverted.
BUSY  out  1  high in FILL and DRAIN.
DONE  out  1  high in REPORT; stays high until the next START or RESET.
PASS  out  1  valid when DONE=1; 1 = all words matched.
ERR_COUNT  out  $clog2(BURST+1)  number of mismatched words in the last run.
FIRST_ERR_IDX  out  $clog2(BURST+1)  index of the first mismatch; BURST if there was none.
FIFO_FULL  out  1  internal FIFO full flag (debug).
FIFO_EMPTY  out  1  internal FIFO empty flag (debug).
LED_R  out  1  active low; lit when DONE and not PASS.
LED_G  out  1  active low; lit when DONE and PASS.
LED_B  out  1  active low; lit while BUSY.

Behaviour:
Reset values (RESET high at an edge):
- State IDLE; FIFO pointers and count cleared (FIFO_EMPTY=1, FIFO_FULL=0).
- BUSY=0, DONE=0, PASS=0, ERR_COUNT=0, FIRST_ERR_IDX=BURST.
- LED_R=LED_G=LED_B=1.
- Applies from any state, including mid-FILL and mid-DRAIN; there is no partial report.

State IDLE:
- START=1 → FILL; write index cleared; ERR_COUNT, DONE, PASS cleared; FIRST_ERR_IDX=BURST.

State FILL:
- Write-enable is high each cycle; one word is written per edge, indices 0..BURST-1.
- After the edge that writes index BURST-1 → DRAIN.

State DRAIN:
- Read-enable is high for BURST consecutive cycles.
- FIFO Q is registered: data for read k is valid the cycle after its read edge and is compared on the following edge.
- Each mismatch increments ERR_COUNT; the first mismatch latches FIRST_ERR_IDX.
- After the edge that compares index BURST-1 → REPORT; PASS = (ERR_COUNT==0), including the final compare.

State REPORT:
- DONE=1. START=1 → FILL, clearing the results exactly as from IDLE.
- START has no effect in FILL or DRAIN.

Timing:
- Edge 0 samples START. Writes occur on edges 1..BURST, reads on BURST+1..2·BURST, compares on BURST+2..2·BURST+1.
- DONE is first high after edge 2·BURST+2. With defaults: edge 8.

FIFO rules:
- Write when full is dropped, with no pointer change.
- Read when empty is dropped, and Q holds its value.
- Simultaneous read and write leaves the count unchanged.
- Pointers wrap modulo DEPTH; the count is $clog2(DEPTH)+1 bits wide.

Decomposition:
- Shared package `fifo_test_pkg`: state enum (IDLE, FILL, DRAIN, REPORT), MODE_INC/MODE_ALT constants, and a pattern function (SEED, MODE, index → word).
- One sub-module, `sync_fifo` (DATA_W, DEPTH): registered Q and FULL/EMPTY flags, clear on RESET. It replaces the vendor FIFO IP so the block is portable and sim-clean.

Test Plan:
1. RESET, then a START pulse with defaults → BUSY high on edges 1–7; DONE=1 after edge 8; PASS=1, ERR_COUNT=0, FIRST_ERR_IDX=3; LED_G=0, LED_R=1, LED_B=1. Read data sequence is 65, 66, 67.
2. INJECT=1 throughout FILL → word 1 is read as 67 instead of 66; ERR_COUNT=1, FIRST_ERR_IDX=1, PASS=0, LED_R=0, LED_G=1.
3. BURST=16, DEPTH=16 → FIFO_FULL=1 after edge 16; FIFO_EMPTY=1 after edge 32; PASS=1; DONE after edge 34. Checks pointer wrap with no drops.
4. START pulsed at edge 3 of a run → ignored, DONE still at edge 8. Second START in REPORT → DONE=0 next cycle and the run repeats with PASS=1.
5. RESET asserted at the first DRAIN edge → next cycle BUSY=0, DONE=0, FIFO_EMPTY=1, all LEDs 1. A subsequent START gives PASS=1, with no stale data.
6. MODE=1, SEED=8'h65, BURST=4 → written pattern is 65, 9A, 65, 9A; PASS=1.
